if_fetch_sramlike: RTL and testbench

- Instruction-fetch stage driving a pipelined SRAM-like instruction bus (req/addr_ok/data_ok).
- Owns the PC and keeps a small in-order buffer of fetched {pc, inst} pairs.
- Presents one instruction per cycle to the decode stage over a valid/ready handshake.
- Consumes the decode stage's redirect (br_e, br_addr): discards wrong-path work and restarts fetch at the target.

---
 rtl/if_fetch_sramlike_if.sv | 29 ++
 rtl/if_fetch_sramlike.sv | 118 +++++++++++
 tb/tb_if_fetch_sramlike.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_sramlike_if.sv
// Fetch-stage bundle: SRAM-like instruction bus, decode redirect and
// the valid/ready delivery port toward decode.
interface if_fetch_sramlike_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        br_e;
    logic [31:0] br_addr;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  br_e, br_addr, id_ready,
        output if_valid, if_pc, if_inst
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output br_e, br_addr, id_ready,
        input  if_valid, if_pc, if_inst
    );
endinterface

// File: rtl/if_fetch_sramlike.sv
// Instruction fetch over a pipelined SRAM-like bus with a small in-order
// {pc, inst} buffer, decode redirect and discard of wrong-path responses.
module if_fetch_sramlike #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          DEPTH    = 2,
    parameter int          CNT_W    = 2
) (
    input logic                 clk,
    input logic                 rst,
    if_fetch_sramlike_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W:0]   CAP  = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [PW-1:0]    LAST = PW'(DEPTH - 1);

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    logic [31:0]      pc;
    logic             rst_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outst;
    logic [CNT_W-1:0] outst_nx;
    logic [CNT_W-1:0] cancel;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    a_wr;
    logic [PW-1:0]    a_rd;
    logic [31:0]      buf_pc   [DEPTH];
    logic [31:0]      buf_inst [DEPTH];
    logic [31:0]      afifo    [DEPTH];
    logic             req;
    logic             accept;
    logic             resp;
    logic             drop;
    logic             push;
    logic             pop;

    // Occupancy plus in-flight requests bounds the buffer, so it never overflows.
    assign req = !rst && !rst_d && !bus.br_e
               && (({1'b0, count} + {1'b0, outst}) < CAP);

    assign accept = req && bus.inst_addr_ok;
    assign resp   = bus.inst_data_ok;
    assign drop   = resp && (cancel != '0);
    assign push   = resp && (cancel == '0) && !bus.br_e;
    assign pop    = (count != '0) && bus.id_ready;

    assign bus.inst_req  = req;
    assign bus.inst_addr = pc;
    assign bus.if_valid  = (count != '0);
    assign bus.if_pc     = buf_pc[head];
    assign bus.if_inst   = buf_inst[head];

    always_comb begin
        outst_nx = outst;
        if (accept && !resp)
            outst_nx = outst + ONE;
        else if (!accept && resp)
            outst_nx = outst - ONE;
    end

    always_ff @(posedge clk) begin
        rst_d <= rst;
    end

    always_ff @(posedge clk) begin
        if (accept) afifo[a_wr] <= pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc[i]   <= '0;
                buf_inst[i] <= '0;
            end
        end else if (push) begin
            buf_pc[tail]   <= afifo[a_rd];
            buf_inst[tail] <= bus.inst_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            count  <= '0;
            outst  <= '0;
            cancel <= '0;
            head   <= '0;
            tail   <= '0;
            a_wr   <= '0;
            a_rd   <= '0;
        end else begin
            outst <= outst_nx;
            if (accept) a_wr <= nxt(a_wr);
            if (resp)   a_rd <= nxt(a_rd);
            if (bus.br_e) begin
                // Everything still in flight belongs to the old path.
                pc     <= bus.br_addr;
                cancel <= outst_nx;
                count  <= '0;
                head   <= '0;
                tail   <= '0;
            end else begin
                if (accept) pc <= pc + 32'd4;
                if (drop)   cancel <= cancel - ONE;
                if (push)   tail <= nxt(tail);
                if (pop)    head <= nxt(head);
                if (push && !pop)
                    count <= count + ONE;
                else if (!push && pop)
                    count <= count - ONE;
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_sramlike.sv
// Scoreboard bench for if_fetch_sramlike: a bus model answers requests,
// a monitor checks every delivery against the expected in-order PC stream.
module tb_if_fetch_sramlike;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] TGT1   = 32'hBFC0_0100;
    localparam logic [31:0] TGT2   = 32'hBFC0_0200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_sramlike_if bus();

    if_fetch_sramlike dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_deliv = 0;

    logic [31:0] exp_q [$];
    logic [31:0] pend  [$];
    logic [31:0] exp_acc = RST_PC;
    logic        hold    = 1'b0;
    logic        dok     = 1'b0;
    logic [31:0] rd      = '0;

    assign bus.inst_data_ok = dok;
    assign bus.inst_rdata   = rd;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic void refill(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
    endfunction

    // Bus: accepts when addr_ok, returns data one cycle later, in order.
    always @(posedge clk) begin
        logic d;
        logic [31:0] r;
        d = 1'b0;
        r = '0;
        if (rst) begin
            pend.delete();
        end else begin
            if (dok) void'(pend.pop_front());
            if (bus.inst_req && bus.inst_addr_ok) begin
                chk("acc_addr", bus.inst_addr, exp_acc);
                exp_acc = exp_acc + 32'd4;
                pend.push_back(bus.inst_addr);
            end
            d = !hold && (pend.size() != 0);
            if (d) r = word(pend[0]);
        end
        dok <= d;
        rd  <= r;
    end

    // Monitor: every handshake on the decode port pops one expectation.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && bus.if_valid && bus.id_ready) begin
            n_deliv++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL deliv_extra: got pc %h expected none", bus.if_pc);
            end else begin
                e = exp_q.pop_front();
                chk("deliv_pc", bus.if_pc, e);
                chk("deliv_inst", bus.if_inst, word(e));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_deliv(input int n, input int budget, input string name);
        int start;
        int k;
        start = n_deliv;
        k = 0;
        while ((n_deliv - start) < n && k < budget) begin
            cyc(1);
            k++;
        end
        n_tests++;
        if ((n_deliv - start) < n) begin
            n_fail++;
            $display("FAIL %s: delivered %0d expected %0d", name, n_deliv - start, n);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   32'(bus.inst_req), 32'd0);
        chk({tag, "_valid"}, 32'(bus.if_valid), 32'd0);
        chk({tag, "_pc"},    bus.if_pc,         32'd0);
        chk({tag, "_inst"},  bus.if_inst,       32'd0);
        chk({tag, "_addr"},  bus.inst_addr,     RST_PC);
    endtask

    initial begin
        int k;
        bus.inst_addr_ok = 1'b1;
        bus.br_e         = 1'b0;
        bus.br_addr      = '0;
        bus.id_ready     = 1'b1;
        refill(RST_PC);

        // Reset state and the dead cycle after release.
        cyc(2);
        @(negedge clk);
        chk_reset("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("req_after_rst", 32'(bus.inst_req), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("first_req", 32'(bus.inst_req), 32'd1);
        chk("first_addr", bus.inst_addr, RST_PC);
        @(posedge clk); #1;
        wait_deliv(8, 40, "p1_stream");

        // Decode stall fills the buffer and stops requests.
        bus.id_ready = 1'b0;
        cyc(5);
        @(negedge clk);
        chk("p2_req_low", 32'(bus.inst_req), 32'd0);
        chk("p2_valid", 32'(bus.if_valid), 32'd1);
        chk("p2_pc_hold", bus.if_pc, exp_q[0]);
        @(posedge clk); #1;
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk("p2_pop0", 32'(bus.if_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("p2_pop1", 32'(bus.if_valid), 32'd1);
        @(posedge clk); #1;
        wait_deliv(4, 30, "p2_resume");

        // Bus withholds addr_ok: request and address must hold still.
        bus.inst_addr_ok = 1'b0;
        cyc(4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("p3_req", 32'(bus.inst_req), 32'd1);
            chk("p3_addr", bus.inst_addr, exp_acc);
            @(posedge clk); #1;
        end
        bus.inst_addr_ok = 1'b1;
        wait_deliv(3, 30, "p3_resume");

        // Redirect with two requests outstanding and the buffer empty.
        hold = 1'b1;
        k = 0;
        while (!(pend.size() == 2 && !bus.if_valid) && k < 20) begin
            cyc(1);
            k++;
        end
        chk("p4_setup", 32'(pend.size()), 32'd2);
        bus.br_e    = 1'b1;
        bus.br_addr = TGT1;
        @(negedge clk);
        chk("p4_req_br", 32'(bus.inst_req), 32'd0);
        @(posedge clk); #1;
        bus.br_e = 1'b0;
        refill(TGT1);
        exp_acc = TGT1;
        cyc(2);
        hold = 1'b0;
        wait_deliv(4, 40, "p4_target");

        // Redirect coinciding with a returning beat and a decode pop.
        bus.inst_addr_ok = 1'b0;
        cyc(5);
        bus.id_ready     = 1'b0;
        bus.inst_addr_ok = 1'b1;
        cyc(1);
        bus.inst_addr_ok = 1'b0;
        cyc(3);
        hold             = 1'b1;
        bus.inst_addr_ok = 1'b1;
        cyc(3);
        hold = 1'b0;
        cyc(1);
        bus.br_e     = 1'b1;
        bus.br_addr  = TGT2;
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk("p5_valid", 32'(bus.if_valid), 32'd1);
        chk("p5_dok", 32'(bus.inst_data_ok), 32'd1);
        chk("p5_req", 32'(bus.inst_req), 32'd0);
        @(posedge clk); #1;
        bus.br_e = 1'b0;
        refill(TGT2);
        exp_acc = TGT2;
        wait_deliv(3, 40, "p5_target");

        // Reset while the buffer holds data and a request is in flight.
        bus.id_ready = 1'b0;
        cyc(5);
        bus.id_ready = 1'b1;
        hold = 1'b1;
        cyc(1);
        bus.id_ready = 1'b0;
        cyc(2);
        rst = 1'b1;
        refill(RST_PC);
        exp_acc = RST_PC;
        @(posedge clk); #1;
        @(negedge clk);
        chk_reset("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        hold = 1'b0;
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk("p6_dead_cycle", 32'(bus.inst_req), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("p6_first_req", 32'(bus.inst_req), 32'd1);
        chk("p6_first_addr", bus.inst_addr, RST_PC);
        @(posedge clk); #1;
        wait_deliv(4, 40, "p6_stream");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
